// File: rtl/controlador_trayectoria_pkg.sv
// Shared definitions for the teach-and-replay trajectory controller.
// Holds the state encoding, the RAM word width derivation and the {x,y} field ranges.
`ifndef CONTROLADOR_TRAYECTORIA_PKG_SV
`define CONTROLADOR_TRAYECTORIA_PKG_SV
`define CT_CAMPO_X(be) (2*(be))-1:(be)
`define CT_CAMPO_Y(be) (be)-1:0
`endif

package controlador_trayectoria_pkg;

  typedef enum logic [2:0] {
    StInicial   = 3'd0,
    StEsperar   = 3'd1,
    StGrabar    = 3'd2,
    StLeer      = 3'd3,
    StCaptura   = 3'd4,
    StPresentar = 3'd5,
    StPausa     = 3'd6
  } estado_e;

  function automatic int unsigned bits_coord(input int unsigned bits_eje);
    return 2 * bits_eje;
  endfunction

  function automatic int unsigned capacidad(input int unsigned bits_dir);
    return 32'd1 << bits_dir;
  endfunction

  function automatic logic es_reproduccion(input estado_e e);
    return (e == StLeer) || (e == StCaptura) || (e == StPresentar) || (e == StPausa);
  endfunction

endpackage

// File: rtl/controlador_trayectoria_contador.sv
// contador_puntos: saturating point count, full flag and the replay index.
// The index only advances while it is below cuenta-1, so it never wraps.
module contador_puntos
  import controlador_trayectoria_pkg::*;
#(
  parameter int unsigned BitsDir = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               borrar_i,
  input  logic               incrementar_i,
  input  logic               indice_cero_i,
  input  logic               indice_avanzar_i,
  output logic [BitsDir:0]   cuenta_o,
  output logic               lleno_o,
  output logic [BitsDir-1:0] indice_o,
  output logic               ultimo_o,
  output logic               hay_puntos_o
);

  localparam logic [BitsDir:0] CuentaMax = (BitsDir + 1)'(capacidad(BitsDir));

  logic [BitsDir:0]   cuenta_d, cuenta_q;
  logic [BitsDir-1:0] indice_d, indice_q;

  always_comb begin
    cuenta_d = cuenta_q;
    indice_d = indice_q;
    if (borrar_i) begin
      cuenta_d = '0;
      indice_d = '0;
    end else begin
      if (incrementar_i && !lleno_o) begin
        cuenta_d = cuenta_q + 1'b1;
      end
      if (indice_cero_i) begin
        indice_d = '0;
      end else if (indice_avanzar_i && !ultimo_o) begin
        indice_d = indice_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cuenta_q <= '0;
      indice_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
      indice_q <= indice_d;
    end
  end

  assign cuenta_o     = cuenta_q;
  assign indice_o     = indice_q;
  assign lleno_o      = (cuenta_q == CuentaMax);
  assign hay_puntos_o = (cuenta_q != '0);
  // With cuenta == 0 the right side is all ones, which a zero-extended index never matches.
  assign ultimo_o     = ({1'b0, indice_q} == (cuenta_q - 1'b1));

endmodule

// File: rtl/controlador_trayectoria.sv
// Teach-and-replay XY controller: records sensor points into an external RAM and
// replays them to the cutting head with a valid/acknowledge handshake.
module controlador_trayectoria
  import controlador_trayectoria_pkg::*;
#(
  parameter int unsigned BITS_EJE = 6,
  parameter int unsigned BITS_DIR = 4,
  localparam int unsigned BITS_COORD = bits_coord(BITS_EJE)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  iniciar_detener,
  input  logic                  pausar_reanudar,
  input  logic                  cancelar,
  input  logic                  guardar_xy,
  input  logic                  cortar,
  input  logic                  repetir,
  input  logic                  dato_siguiente,
  input  logic [BITS_EJE-1:0]   x_sensor,
  input  logic [BITS_EJE-1:0]   y_sensor,
  input  logic [BITS_COORD-1:0] mem_dato_leer,
  output logic [BITS_DIR-1:0]   mem_dir,
  output logic [BITS_COORD-1:0] mem_dato_escribir,
  output logic                  mem_escribir,
  output logic [BITS_EJE-1:0]   x_salida,
  output logic [BITS_EJE-1:0]   y_salida,
  output logic                  punto_valido,
  output logic                  cortando,
  output logic                  en_pausa,
  output logic                  corte_terminado,
  output logic                  lleno,
  output logic [BITS_DIR:0]     cuenta_puntos
);

  estado_e             estado_d, estado_q;
  logic [BITS_EJE-1:0] x_d, x_q;
  logic [BITS_EJE-1:0] y_d, y_q;
  logic                corte_d, corte_q;

  logic [BITS_DIR:0]   cuenta;
  logic [BITS_DIR-1:0] indice;
  logic                ultimo;
  logic                hay_puntos;
  logic                borrar;
  logic                incrementar;
  logic                indice_cero;
  logic                indice_avanzar;

  contador_puntos #(
    .BitsDir (BITS_DIR)
  ) u_contador_puntos (
    .clk_i            (clock),
    .rst_ni           (reset_n),
    .borrar_i         (borrar),
    .incrementar_i    (incrementar),
    .indice_cero_i    (indice_cero),
    .indice_avanzar_i (indice_avanzar),
    .cuenta_o         (cuenta),
    .lleno_o          (lleno),
    .indice_o         (indice),
    .ultimo_o         (ultimo),
    .hay_puntos_o     (hay_puntos)
  );

  always_comb begin
    estado_d       = estado_q;
    x_d            = x_q;
    y_d            = y_q;
    corte_d        = 1'b0;
    borrar         = 1'b0;
    incrementar    = 1'b0;
    indice_cero    = 1'b0;
    indice_avanzar = 1'b0;

    // RAM data addressed in LEER is valid now, whatever the next state turns out to be.
    if (estado_q == StCaptura) begin
      x_d = mem_dato_leer[`CT_CAMPO_X(BITS_EJE)];
      y_d = mem_dato_leer[`CT_CAMPO_Y(BITS_EJE)];
    end

    if (cancelar) begin
      estado_d = StInicial;
      borrar   = 1'b1;
    end else begin
      unique case (estado_q)
        StInicial: begin
          if (iniciar_detener) estado_d = StEsperar;
        end
        StEsperar: begin
          if (iniciar_detener) begin
            estado_d = StInicial;
          end else if (cortar && hay_puntos) begin
            estado_d    = StLeer;
            indice_cero = 1'b1;
          end else if (guardar_xy && !lleno) begin
            estado_d = StGrabar;
          end
        end
        StGrabar: begin
          incrementar = 1'b1;
          estado_d    = StEsperar;
        end
        StLeer: begin
          estado_d = iniciar_detener ? StEsperar : StCaptura;
        end
        StCaptura: begin
          estado_d = iniciar_detener ? StEsperar : StPresentar;
        end
        StPresentar: begin
          if (iniciar_detener) begin
            estado_d = StEsperar;
          end else if (pausar_reanudar) begin
            estado_d = StPausa;
          end else if (dato_siguiente) begin
            if (ultimo) begin
              corte_d = 1'b1;
              if (repetir) begin
                indice_cero = 1'b1;
                estado_d    = StLeer;
              end else begin
                estado_d = StEsperar;
              end
            end else begin
              indice_avanzar = 1'b1;
              estado_d       = StLeer;
            end
          end
        end
        StPausa: begin
          if (iniciar_detener) begin
            estado_d = StEsperar;
          end else if (pausar_reanudar) begin
            estado_d = StPresentar;
          end
        end
        default: estado_d = StInicial;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= StInicial;
      x_q      <= '0;
      y_q      <= '0;
      corte_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      x_q      <= x_d;
      y_q      <= y_d;
      corte_q  <= corte_d;
    end
  end

  always_comb begin
    mem_dir = '0;
    if (estado_q == StGrabar) begin
      mem_dir = cuenta[BITS_DIR-1:0];
    end else if (estado_q == StLeer) begin
      mem_dir = indice;
    end
  end

  assign mem_escribir      = (estado_q == StGrabar);
  // Sensors are sampled live during the write cycle itself.
  assign mem_dato_escribir = mem_escribir ? {x_sensor, y_sensor} : '0;
  assign x_salida          = x_q;
  assign y_salida          = y_q;
  assign punto_valido      = (estado_q == StPresentar);
  assign cortando          = es_reproduccion(estado_q);
  assign en_pausa          = (estado_q == StPausa);
  assign corte_terminado   = corte_q;
  assign cuenta_puntos     = cuenta;

endmodule

// File: tb/tb_controlador_trayectoria.sv
// Bench for controlador_trayectoria: directed test-plan sequences plus random stimulus,
// all checked every cycle against a behavioural model of the controller and its RAM.
module tb_controlador_trayectoria;

  localparam int BE  = 6;
  localparam int BD  = 2;
  localparam int BC  = 2 * BE;
  localparam int CAP = 1 << BD;

  localparam logic [5:0] P_CAN = 6'b100000;
  localparam logic [5:0] P_INI = 6'b010000;
  localparam logic [5:0] P_PAU = 6'b001000;
  localparam logic [5:0] P_COR = 6'b000100;
  localparam logic [5:0] P_GUA = 6'b000010;
  localparam logic [5:0] P_ACK = 6'b000001;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          iniciar_detener = 1'b0;
  logic          pausar_reanudar = 1'b0;
  logic          cancelar = 1'b0;
  logic          guardar_xy = 1'b0;
  logic          cortar = 1'b0;
  logic          repetir = 1'b0;
  logic          dato_siguiente = 1'b0;
  logic [BE-1:0] x_sensor = '0;
  logic [BE-1:0] y_sensor = '0;
  logic [BC-1:0] mem_dato_leer = '0;
  logic [BD-1:0] mem_dir;
  logic [BC-1:0] mem_dato_escribir;
  logic          mem_escribir;
  logic [BE-1:0] x_salida;
  logic [BE-1:0] y_salida;
  logic          punto_valido;
  logic          cortando;
  logic          en_pausa;
  logic          corte_terminado;
  logic          lleno;
  logic [BD:0]   cuenta_puntos;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  controlador_trayectoria #(
    .BITS_EJE (BE),
    .BITS_DIR (BD)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .iniciar_detener   (iniciar_detener),
    .pausar_reanudar   (pausar_reanudar),
    .cancelar          (cancelar),
    .guardar_xy        (guardar_xy),
    .cortar            (cortar),
    .repetir           (repetir),
    .dato_siguiente    (dato_siguiente),
    .x_sensor          (x_sensor),
    .y_sensor          (y_sensor),
    .mem_dato_leer     (mem_dato_leer),
    .mem_dir           (mem_dir),
    .mem_dato_escribir (mem_dato_escribir),
    .mem_escribir      (mem_escribir),
    .x_salida          (x_salida),
    .y_salida          (y_salida),
    .punto_valido      (punto_valido),
    .cortando          (cortando),
    .en_pausa          (en_pausa),
    .corte_terminado   (corte_terminado),
    .lleno             (lleno),
    .cuenta_puntos     (cuenta_puntos)
  );

  // External synchronous RAM: read data one cycle after the address.
  logic [BC-1:0] ram [CAP];
  always @(posedge clock) begin
    if (mem_escribir) ram[mem_dir] <= mem_dato_escribir;
    mem_dato_leer <= ram[mem_dir];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: activity name, recorded points as x*64+y, count, index.
  string m_mode = "INI";
  int    m_cnt = 0;
  int    m_idx = 0;
  int    m_x = 0;
  int    m_y = 0;
  int    m_fin = 0;
  int    m_pts [CAP];

  task automatic model_step();
    if (!reset_n) begin
      m_mode = "INI"; m_cnt = 0; m_idx = 0; m_x = 0; m_y = 0; m_fin = 0;
    end else begin
      if (m_mode == "GRAB") m_pts[m_cnt % CAP] = int'(x_sensor) * (1 << BE) + int'(y_sensor);
      if (m_mode == "CAPT") begin
        m_x = m_pts[m_idx] / (1 << BE);
        m_y = m_pts[m_idx] % (1 << BE);
      end
      m_fin = 0;
      if (cancelar) begin
        m_mode = "INI"; m_cnt = 0; m_idx = 0;
      end else if (m_mode == "INI") begin
        if (iniciar_detener) m_mode = "ESP";
      end else if (m_mode == "ESP") begin
        if (iniciar_detener) m_mode = "INI";
        else if (cortar && m_cnt > 0) begin m_mode = "READ"; m_idx = 0; end
        else if (guardar_xy && m_cnt < CAP) m_mode = "GRAB";
      end else if (m_mode == "GRAB") begin
        m_cnt = (m_cnt + 1 > CAP) ? CAP : m_cnt + 1;
        m_mode = "ESP";
      end else if (m_mode == "READ") begin
        m_mode = iniciar_detener ? "ESP" : "CAPT";
      end else if (m_mode == "CAPT") begin
        m_mode = iniciar_detener ? "ESP" : "PRES";
      end else if (m_mode == "PRES") begin
        if (iniciar_detener) m_mode = "ESP";
        else if (pausar_reanudar) m_mode = "PAUSE";
        else if (dato_siguiente) begin
          if (m_idx < m_cnt - 1) begin m_idx++; m_mode = "READ"; end
          else begin
            m_fin = 1;
            if (repetir) begin m_idx = 0; m_mode = "READ"; end
            else m_mode = "ESP";
          end
        end
      end else if (m_mode == "PAUSE") begin
        if (iniciar_detener) m_mode = "ESP";
        else if (pausar_reanudar) m_mode = "PRES";
      end
    end
  endtask

  task automatic compare();
    int rep;
    int exp_dir;
    rep = (m_mode == "READ" || m_mode == "CAPT" || m_mode == "PRES" || m_mode == "PAUSE");
    exp_dir = (m_mode == "GRAB") ? m_cnt % CAP : ((m_mode == "READ") ? m_idx : 0);
    if (!reset_n) begin
      check("rst_mem_escribir", mem_escribir, 0);
      check("rst_punto_valido", punto_valido, 0);
      check("rst_cortando", cortando, 0);
      check("rst_cuenta", cuenta_puntos, 0);
      check("rst_xy", {x_salida, y_salida}, 0);
    end else begin
      check("mem_escribir", mem_escribir, m_mode == "GRAB");
      check("mem_dir", mem_dir, exp_dir);
      check("mem_dato_escribir", mem_dato_escribir,
            (m_mode == "GRAB") ? int'(x_sensor) * (1 << BE) + int'(y_sensor) : 0);
      check("punto_valido", punto_valido, m_mode == "PRES");
      check("cortando", cortando, rep);
      check("en_pausa", en_pausa, m_mode == "PAUSE");
      check("corte_terminado", corte_terminado, m_fin);
      check("lleno", lleno, m_cnt == CAP);
      check("cuenta_puntos", cuenta_puntos, m_cnt);
      check("x_salida", x_salida, m_x);
      check("y_salida", y_salida, m_y);
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    compare();
  end

  task automatic step(input logic [5:0] p);
    {cancelar, iniciar_detener, pausar_reanudar, cortar, guardar_xy, dato_siguiente} = p;
    @(posedge clock);
    #2;
    {cancelar, iniciar_detener, pausar_reanudar, cortar, guardar_xy, dato_siguiente} = '0;
  endtask

  task automatic rec(input int x, input int y, input int word, input int addr);
    x_sensor = BE'(x);
    y_sensor = BE'(y);
    step(P_GUA);
    check("rec_strobe", mem_escribir, 1);
    check("rec_word", mem_dato_escribir, word);
    check("rec_addr", mem_dir, addr);
    step('0);
    check("rec_strobe_low", mem_escribir, 0);
  endtask

  task automatic reach_point(input int x, input int y);
    step('0);
    check("wait_pv_low", punto_valido, 0);
    step('0);
    check("pv_high", punto_valido, 1);
    check("pt_x", x_salida, x);
    check("pt_y", y_salida, y);
  endtask

  int ex [3] = '{5, 10, 63};
  int ey [3] = '{9, 20, 0};
  int pulsos;

  initial begin
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    step(P_INI);
    rec(5, 9, 'h149, 0);
    rec(10, 20, 'h294, 1);
    rec(63, 0, 'hFC0, 2);
    check("cuenta_3", cuenta_puntos, 3);

    // Single pass replay.
    step(P_COR);
    check("leer_cortando", cortando, 1);
    check("leer_pv", punto_valido, 0);
    reach_point(ex[0], ey[0]);
    for (int i = 1; i < 3; i++) begin
      step(P_ACK);
      check("mid_no_fin", corte_terminado, 0);
      reach_point(ex[i], ey[i]);
    end
    step(P_ACK);
    check("fin_pulse", corte_terminado, 1);
    check("fin_idle", cortando, 0);
    step('0);
    check("fin_pulse_one", corte_terminado, 0);

    // Pause coinciding with the acknowledge of point 1.
    step(P_COR);
    reach_point(ex[0], ey[0]);
    step(P_ACK);
    reach_point(ex[1], ey[1]);
    step(P_PAU | P_ACK);
    check("pausa", en_pausa, 1);
    check("pausa_pv", punto_valido, 0);
    check("pausa_x", x_salida, 10);
    step('0);
    step(P_PAU);
    check("reanuda_pv", punto_valido, 1);
    check("reanuda_x", x_salida, 10);
    check("reanuda_y", y_salida, 20);
    step(P_INI);
    check("stop_cortando", cortando, 0);

    // Cyclic replay for two passes.
    repetir = 1'b1;
    pulsos = 0;
    step(P_COR);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) begin
        reach_point(ex[i], ey[i]);
        step(P_ACK);
        if (corte_terminado) pulsos++;
      end
    end
    check("rep_pulsos", pulsos, 2);
    reach_point(ex[0], ey[0]);
    step(P_INI);
    repetir = 1'b0;
    check("rep_stop", cortando, 0);
    check("rep_cuenta", cuenta_puntos, 3);

    // Fill the RAM; the fifth point must be dropped.
    rec(1, 2, 'h042, 3);
    check("lleno", lleno, 1);
    check("cuenta_4", cuenta_puntos, 4);
    step(P_GUA);
    check("full_no_write", mem_escribir, 0);
    step('0);
    check("full_cuenta", cuenta_puntos, 4);

    // Cancel mid-replay.
    step(P_COR);
    reach_point(ex[0], ey[0]);
    step(P_CAN);
    check("cancel_cuenta", cuenta_puntos, 0);
    check("cancel_cortando", cortando, 0);
    check("cancel_lleno", lleno, 0);

    // cortar with nothing recorded is ignored.
    step(P_INI);
    step(P_COR);
    check("cortar_vacio", cortando, 0);
    step('0);

    // Reset during replay, then during a write.
    rec(3, 4, 'h0C4, 0);
    step(P_COR);
    reach_point(3, 4);
    reset_n = 1'b0;
    #1;
    check("arst_pv", punto_valido, 0);
    check("arst_x", x_salida, 0);
    check("arst_cuenta", cuenta_puntos, 0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    step(P_INI);
    x_sensor = 6'd7;
    y_sensor = 6'd7;
    step(P_GUA);
    reset_n = 1'b0;
    #1;
    check("arst_write", mem_escribir, 0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;

    // Random stimulus against the model.
    for (int c = 0; c < 4000; c++) begin
      reset_n         = ($urandom_range(0, 599) != 0);
      cancelar        = ($urandom_range(0, 79) == 0);
      iniciar_detener = ($urandom_range(0, 29) == 0);
      pausar_reanudar = ($urandom_range(0, 11) == 0);
      cortar          = ($urandom_range(0, 5) == 0);
      guardar_xy      = ($urandom_range(0, 3) == 0);
      dato_siguiente  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) repetir = ~repetir;
      x_sensor = BE'($urandom);
      y_sensor = BE'($urandom);
      @(posedge clock);
      #2;
    end
    reset_n = 1'b1;
    step('0);
    step('0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
